cpu_bus_responder: RTL and testbench

Bus target for the cpu_65816 core. It sits between the CPU's de-multiplexed bus (ADDR_OUT/DO/WE/VDA/VPA/VPB) and a generic memory backend with a req/ack handshake. It converts each valid CPU bus cycle into one backend transaction, stalling the CPU via RDY until data is available. It also inserts programmable wait states, remaps vector pulls to a dedicated bank, and reports backend timeouts.

---
 rtl/cpu_bus_responder.sv | 131 +++++++++++++
 tb/tb_cpu_bus_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: bus target for the cpu_65816 core.
// Turns each valid CPU bus cycle into a single req/ack transaction on a
// generic memory backend, holding the CPU off with cpu_rdy until the data
// is back. Supports optional wait states before each request, relocation
// of vector pulls into a dedicated bank, and a sticky timeout error flag.
module cpu_bus_responder #(
  parameter int          WAIT_STATES = 0,      // 0..15 stall cycles before each request
  parameter int          TIMEOUT     = 64,     // 1..255 REQ cycles before abort
  parameter logic [7:0]  VECTOR_BANK = 8'h00,  // bank used for vector pulls from bank 00
  parameter logic [7:0]  OPEN_BUS    = 8'hFF   // read data returned on timeout
) (
  input  logic        CLK,
  input  logic        RST,
  // CPU side
  input  logic [23:0] cpu_addr,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  input  logic        cpu_vda,
  input  logic        cpu_vpa,
  input  logic        cpu_vpb,
  output logic [7:0]  cpu_di,
  output logic        cpu_rdy,
  // backend side
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  // error reporting
  input  logic        err_clr,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ,
    ST_DONE
  } state_t;

  // Terminal counts; WAIT_LAST is never consulted when WAIT_STATES is 0.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [7:0] to_cnt;

  logic cpu_access;
  logic vec_pull;

  // A valid data or program address means the CPU wants this bus cycle served.
  assign cpu_access = cpu_vda | cpu_vpa;
  // Vector fetches from bank 00 are steered into VECTOR_BANK.
  assign vec_pull   = !cpu_vpb && (cpu_addr[23:16] == 8'h00);

  // Ready is combinational so an idle/internal CPU cycle never stalls.
  assign cpu_rdy = (state == ST_DONE) || ((state == ST_IDLE) && !cpu_access);

  // Access sequencer: latch the CPU cycle, optionally wait, request, then hand back.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order in the block.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 24'h000000;
      mem_wdata <= 8'h00;
      cpu_di    <= OPEN_BUS;
      bus_err   <= 1'b0;
      wait_cnt  <= 4'd0;
      to_cnt    <= 8'd0;
    end else begin
      // Clear first; a timeout later in this block overrides it, so set wins.
      if (err_clr) bus_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cpu_access) begin
            mem_addr  <= vec_pull ? {VECTOR_BANK, cpu_addr[15:0]} : cpu_addr;
            mem_we    <= cpu_we;
            mem_wdata <= cpu_do;
            if (WAIT_STATES > 0) begin
              state <= ST_WAIT;
            end else begin
              state   <= ST_REQ;
              mem_req <= 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= 4'd0;
            state    <= ST_REQ;
            mem_req  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        ST_REQ: begin
          // Ack is tested before the timeout so a same-cycle ack is accepted.
          if (mem_ack) begin
            if (!mem_we) cpu_di <= mem_rdata;
            mem_req <= 1'b0;
            state   <= ST_DONE;
          end else if (to_cnt == TO_LAST) begin
            if (!mem_we) cpu_di <= OPEN_BUS;
            bus_err <= 1'b1;
            mem_req <= 1'b0;
            state   <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end

        ST_DONE: begin
          wait_cnt <= 4'd0;
          to_cnt   <= 8'd0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench for cpu_bus_responder.
// Instance 0: WAIT_STATES=0, TIMEOUT=4, VECTOR_BANK=7F.
// Instance 1: WAIT_STATES=3, default TIMEOUT and VECTOR_BANK.
// Stimulus pushes hand-computed expectations; a monitor pops one per
// completed access (cpu_rdy high after at least one stall cycle).
module tb_cpu_bus_responder;

  logic             CLK;
  logic             RST;
  logic [1:0][23:0] cpu_addr;
  logic [1:0][7:0]  cpu_do;
  logic [1:0]       cpu_we;
  logic [1:0]       cpu_vda;
  logic [1:0]       cpu_vpa;
  logic [1:0]       cpu_vpb;
  logic [1:0][7:0]  cpu_di;
  logic [1:0]       cpu_rdy;
  logic [1:0]       mem_req;
  logic [1:0]       mem_we;
  logic [1:0][23:0] mem_addr;
  logic [1:0][7:0]  mem_wdata;
  logic [1:0][7:0]  mem_rdata;
  logic [1:0]       mem_ack;
  logic [1:0]       err_clr;
  logic [1:0]       bus_err;

  // Backend model controls
  logic [1:0]       ack_resp;
  logic [1:0]       stray_ack;
  int               ack_at  [2];
  logic [7:0]       rd_cfg  [2];
  int               req_idx [2];

  assign mem_ack = ack_resp | stray_ack;

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  di;
    logic        err;
    int          req;
    int          stall;
  } exp_t;

  exp_t exp_q [2][$];

  int n_vec;
  int n_err;

  cpu_bus_responder #(
    .WAIT_STATES(0), .TIMEOUT(4), .VECTOR_BANK(8'h7F), .OPEN_BUS(8'hFF)
  ) u0 (
    .CLK(CLK), .RST(RST),
    .cpu_addr(cpu_addr[0]), .cpu_do(cpu_do[0]), .cpu_we(cpu_we[0]),
    .cpu_vda(cpu_vda[0]), .cpu_vpa(cpu_vpa[0]), .cpu_vpb(cpu_vpb[0]),
    .cpu_di(cpu_di[0]), .cpu_rdy(cpu_rdy[0]),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ack(mem_ack[0]),
    .err_clr(err_clr[0]), .bus_err(bus_err[0])
  );

  cpu_bus_responder #(
    .WAIT_STATES(3)
  ) u1 (
    .CLK(CLK), .RST(RST),
    .cpu_addr(cpu_addr[1]), .cpu_do(cpu_do[1]), .cpu_we(cpu_we[1]),
    .cpu_vda(cpu_vda[1]), .cpu_vpa(cpu_vpa[1]), .cpu_vpb(cpu_vpb[1]),
    .cpu_di(cpu_di[1]), .cpu_rdy(cpu_rdy[1]),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ack(mem_ack[1]),
    .err_clr(err_clr[1]), .bus_err(bus_err[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Backend: ack in REQ cycle number ack_at (0-based); large ack_at never acks.
  initial begin
    ack_resp = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_idx[i] = 0;
      ack_at[i]  = 0;
      rd_cfg[i]  = 8'h00;
    end
    mem_rdata = '0;
    forever begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < 2; i++) begin
        ack_resp[i] = 1'b0;
        if (mem_req[i]) begin
          if (req_idx[i] == ack_at[i]) begin
            ack_resp[i]  = 1'b1;
            mem_rdata[i] = rd_cfg[i];
          end
          req_idx[i]++;
        end else begin
          req_idx[i] = 0;
        end
      end
    end
  end

  // Monitor: count stall and request cycles, compare on each completion.
  initial begin
    int   stall_cnt [2];
    int   req_cnt   [2];
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      stall_cnt[i] = 0;
      req_cnt[i]   = 0;
    end
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        if (RST) begin
          stall_cnt[i] = 0;
          req_cnt[i]   = 0;
        end else begin
          if (mem_req[i]) req_cnt[i]++;
          if (!cpu_rdy[i]) begin
            stall_cnt[i]++;
          end else if (stall_cnt[i] > 0) begin
            if (exp_q[i].size() == 0) begin
              check($sformatf("u%0d_unexpected_completion", i), 32'd1, 32'd0);
            end else begin
              e = exp_q[i].pop_front();
              check($sformatf("u%0d_mem_addr", i), 32'(mem_addr[i]), 32'(e.addr));
              check($sformatf("u%0d_mem_we", i), 32'(mem_we[i]), 32'(e.we));
              if (e.we) check($sformatf("u%0d_mem_wdata", i), 32'(mem_wdata[i]), 32'(e.wdata));
              check($sformatf("u%0d_cpu_di", i), 32'(cpu_di[i]), 32'(e.di));
              check($sformatf("u%0d_bus_err", i), 32'(bus_err[i]), 32'(e.err));
              check($sformatf("u%0d_req_cycles", i), 32'(req_cnt[i]), 32'(e.req));
              check($sformatf("u%0d_stall_cycles", i), 32'(stall_cnt[i]), 32'(e.stall));
            end
            stall_cnt[i] = 0;
            req_cnt[i]   = 0;
          end
        end
      end
    end
  end

  // One CPU access on instance i, with hand-computed expectations.
  task automatic do_access(
    input int          i,
    input logic [23:0] a,
    input logic [7:0]  d,
    input logic        we,
    input logic        vda,
    input logic        vpa,
    input logic        vpb,
    input int          ack_after,
    input logic [7:0]  rd,
    input logic [23:0] e_addr,
    input logic [7:0]  e_di,
    input logic        e_err,
    input int          e_req,
    input int          e_stall
  );
    exp_t e;
    bit   done;
    e.addr = e_addr; e.we = we; e.wdata = d; e.di = e_di;
    e.err  = e_err;  e.req = e_req; e.stall = e_stall;
    exp_q[i].push_back(e);
    @(posedge CLK);
    #1;
    ack_at[i]   = ack_after;
    rd_cfg[i]   = rd;
    cpu_addr[i] = a;
    cpu_do[i]   = d;
    cpu_we[i]   = we;
    cpu_vpb[i]  = vpb;
    cpu_vda[i]  = vda;
    cpu_vpa[i]  = vpa;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (cpu_rdy[i]) done = 1'b1;
    end
    if (!done) check($sformatf("u%0d_rdy_wait_expired", i), 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    cpu_vda[i] = 1'b0;
    cpu_vpa[i] = 1'b0;
    cpu_we[i]  = 1'b0;
    cpu_vpb[i] = 1'b1;
  endtask

  initial begin
    bit seen;
    n_vec = 0;
    n_err = 0;
    RST = 1'b1;
    cpu_addr = '0; cpu_do = '0; cpu_we = '0;
    cpu_vda = '0; cpu_vpa = '0; cpu_vpb = 2'b11;
    err_clr = '0; stray_ack = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_mem_req", 32'(mem_req[0]), 32'd0);
    check("rst_mem_we", 32'(mem_we[0]), 32'd0);
    check("rst_mem_addr", 32'(mem_addr[0]), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata[0]), 32'd0);
    check("rst_cpu_di", 32'(cpu_di[0]), 32'hFF);
    check("rst_bus_err", 32'(bus_err[0]), 32'd0);
    check("rst_cpu_rdy", 32'(cpu_rdy[0]), 32'd1);
    check("rst_u1_cpu_di", 32'(cpu_di[1]), 32'hFF);
    @(posedge CLK);
    #1 RST = 1'b0;

    // Instance 1 (3 wait states): read, write leaves cpu_di, vector with bank 00
    do_access(1, 24'h000100, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 0, 8'h11,
              24'h000100, 8'h11, 1'b0, 1, 5);
    do_access(1, 24'h00C000, 8'hA7, 1'b1, 1'b1, 1'b0, 1'b1, 0, 8'h00,
              24'h00C000, 8'h11, 1'b0, 1, 5);
    do_access(1, 24'h00FFFE, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h22,
              24'h00FFFE, 8'h22, 1'b0, 1, 5);

    // Instance 0: minimum-latency read
    do_access(0, 24'h012345, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 0, 8'h5A,
              24'h012345, 8'h5A, 1'b0, 1, 2);
    // Vector remap
    do_access(0, 24'h00FFFC, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h34,
              24'h7FFFFC, 8'h34, 1'b0, 1, 2);
    do_access(0, 24'h00FFFC, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 0, 8'h12,
              24'h00FFFC, 8'h12, 1'b0, 1, 2);
    do_access(0, 24'h01FFFC, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h56,
              24'h01FFFC, 8'h56, 1'b0, 1, 2);

    // Timeout: 4 REQ cycles, open-bus data, sticky error
    do_access(0, 24'h020000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1000, 8'h00,
              24'h020000, 8'hFF, 1'b1, 4, 5);
    @(negedge CLK);
    check("err_sticky", 32'(bus_err[0]), 32'd1);
    @(posedge CLK); #1 err_clr[0] = 1'b1;
    @(posedge CLK); #1 err_clr[0] = 1'b0;
    @(negedge CLK);
    check("err_clr", 32'(bus_err[0]), 32'd0);

    // Timeout with err_clr held: set wins
    err_clr[0] = 1'b1;
    do_access(0, 24'h020001, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1000, 8'h00,
              24'h020001, 8'hFF, 1'b1, 4, 5);
    err_clr[0] = 1'b0;
    @(negedge CLK);
    check("err_clr_after_set", 32'(bus_err[0]), 32'd0);

    // Ack on the last allowed REQ cycle wins over timeout
    do_access(0, 24'h030000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3, 8'hC3,
              24'h030000, 8'hC3, 1'b0, 4, 5);
    // Write does not touch cpu_di
    do_access(0, 24'h123456, 8'h99, 1'b1, 1'b1, 1'b0, 1'b1, 0, 8'hEE,
              24'h123456, 8'hC3, 1'b0, 1, 2);

    // Idle cycles with a stray ack
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin
        @(posedge CLK); #1 stray_ack[0] = 1'b1;
        @(posedge CLK); #1 stray_ack[0] = 1'b0;
      end
      @(negedge CLK);
      check("idle_rdy", 32'(cpu_rdy[0]), 32'd1);
      check("idle_req", 32'(mem_req[0]), 32'd0);
    end
    check("idle_di_kept", 32'(cpu_di[0]), 32'hC3);
    check("idle_err", 32'(bus_err[0]), 32'd0);

    // Reset in the middle of REQ
    @(posedge CLK);
    #1;
    ack_at[0]   = 1000;
    cpu_addr[0] = 24'h000200;
    cpu_vda[0]  = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge CLK);
      if (mem_req[0]) seen = 1'b1;
    end
    check("rst_mid_req_reached", 32'(seen), 32'd1);
    RST = 1'b1;
    #1;
    check("rst_mid_req_drop", 32'(mem_req[0]), 32'd0);
    check("rst_mid_req_di", 32'(cpu_di[0]), 32'hFF);
    cpu_vda[0] = 1'b0;
    @(negedge CLK);
    @(posedge CLK); #1 RST = 1'b0;
    stray_ack[0] = 1'b1;
    @(posedge CLK); #1 stray_ack[0] = 1'b0;
    @(negedge CLK);
    check("post_rst_ack_req", 32'(mem_req[0]), 32'd0);
    check("post_rst_ack_di", 32'(cpu_di[0]), 32'hFF);
    check("post_rst_ack_rdy", 32'(cpu_rdy[0]), 32'd1);
    do_access(0, 24'h000300, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 0, 8'h77,
              24'h000300, 8'h77, 1'b0, 1, 2);

    // Drain scoreboard
    for (int c = 0; c < 20 && (exp_q[0].size() + exp_q[1].size()) > 0; c++)
      @(negedge CLK);
    check("u0_queue_drained", 32'(exp_q[0].size()), 32'd0);
    check("u1_queue_drained", 32'(exp_q[1].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
